// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel round-robin arbiter feeding a registered one-word output stage.
// Define ARB_MUX_LOCK_EN to add the lock port that holds the grant on one channel.
module arb_mux_rr #(
  parameter int N = 8,
  parameter int W = 32,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
`ifdef ARB_MUX_LOCK_EN
  ,
  input  logic              lock
`endif
);

  logic [SELW-1:0] ptr_r;
  logic            rr_found_s;
  logic [SELW-1:0] rr_idx_s;
  logic [SELW:0]   scan_sum_s;
  logic [SELW-1:0] scan_idx_s;
  logic            grant_found_s;
  logic [SELW-1:0] grant_idx_s;
  logic [W-1:0]    grant_data_s;
  logic [SELW-1:0] next_ptr_s;
  logic            load_en_s;
  logic            xfer_s;
  logic            ptr_adv_s;

  // Rotating-priority scan; walking offsets downward lets the nearest requester win.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    scan_sum_s = '0;
    scan_idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan_sum_s = {1'b0, ptr_r} + (SELW+1)'(i);
      if (scan_sum_s >= (SELW+1)'(N)) begin
        scan_sum_s = scan_sum_s - (SELW+1)'(N);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[SELW-1:0];
      if (in_valid[scan_idx_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = scan_idx_s;
      end else begin
        rr_found_s = rr_found_s;
        rr_idx_s   = rr_idx_s;
      end
    end
  end

`ifdef ARB_MUX_LOCK_EN
  logic            locked_r;
  logic [SELW-1:0] locked_ch_r;

  // While locked only the locked channel may be granted, even when it is idle.
  always_comb begin
    if (locked_r) begin
      grant_found_s = in_valid[locked_ch_r];
      grant_idx_s   = locked_ch_r;
    end else begin
      grant_found_s = rr_found_s;
      grant_idx_s   = rr_idx_s;
    end
  end

  assign ptr_adv_s = xfer_s & ~lock;

  // Lock state follows the lock input on every channel transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_r    <= 1'b0;
      locked_ch_r <= '0;
    end else if (xfer_s) begin
      locked_r    <= lock;
      locked_ch_r <= grant_idx_s;
    end else begin
      locked_r    <= locked_r;
      locked_ch_r <= locked_ch_r;
    end
  end
`else
  assign grant_found_s = rr_found_s;
  assign grant_idx_s   = rr_idx_s;
  assign ptr_adv_s     = xfer_s;
`endif

  assign load_en_s  = ~out_valid | out_ready;
  assign xfer_s     = grant_found_s & load_en_s & ~rst;
  assign next_ptr_s = (grant_idx_s == SELW'(N - 1)) ? '0 : grant_idx_s + SELW'(1);

  // One-hot accept for the granted channel and its data word.
  always_comb begin
    in_ready     = '0;
    grant_data_s = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_idx_s == SELW'(k)) begin
        in_ready[k]  = xfer_s;
        grant_data_s = in_data[k*W +: W];
      end else begin
        in_ready[k]  = 1'b0;
        grant_data_s = grant_data_s;
      end
    end
  end

  // Output register: reload on channel transfer, drain on output-only transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_r     <= '0;
    end else begin
      if (xfer_s) begin
        out_valid <= 1'b1;
        out_data  <= grant_data_s;
        out_sel   <= grant_idx_s;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      if (ptr_adv_s) begin
        ptr_r <= next_ptr_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_rr.sv
// Bench for arb_mux_rr: N=8 instance checked every cycle against a queue-free reference model,
// plus an N=5 instance for the non-power-of-two pointer wrap.
module tb_arb_mux_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data8;
  logic [7:0]   in_valid8;
  logic [7:0]   in_ready8;
  logic [31:0]  out_data8;
  logic [2:0]   out_sel8;
  logic         out_valid8;
  logic         out_ready8;

  logic [159:0] in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic [31:0]  out_data5;
  logic [2:0]   out_sel5;
  logic         out_valid5;
  logic         out_ready5;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(.N(8), .W(32)) u_dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .out_data(out_data8), .out_sel(out_sel8), .out_valid(out_valid8), .out_ready(out_ready8)
`ifdef ARB_MUX_LOCK_EN
    , .lock(1'b0)
`endif
  );

  arb_mux_rr #(.N(5), .W(32)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5)
`ifdef ARB_MUX_LOCK_EN
    , .lock(1'b0)
`endif
  );

  function automatic logic [31:0] word8(input int k);
    return 32'hA5A5_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending word plus the channel that has top priority next.
  int          m_ptr   = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = 32'h0;
  logic [2:0]  m_sel   = 3'd0;

  function automatic int m_grant();
    for (int i = 0; i < 8; i++)
      if (in_valid8[(m_ptr + i) % 8]) return (m_ptr + i) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready();
    int g;
    g = m_grant();
    if (rst || (m_valid && !out_ready8) || g < 0) return 8'h00;
    return 8'h01 << g;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 0; m_valid <= 1'b0; m_data <= 32'h0; m_sel <= 3'd0;
    end else if (exp_ready() != 8'h00) begin
      m_valid <= 1'b1;
      m_sel   <= 3'(m_grant());
      m_data  <= in_data8[m_grant()*32 +: 32];
      m_ptr   <= (m_grant() + 1) % 8;
    end else if (out_ready8) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  32'(in_ready8),  32'(exp_ready()));
    chk("out_valid", 32'(out_valid8), 32'(m_valid));
    chk("out_data",  out_data8,       m_data);
    chk("out_sel",   32'(out_sel8),   32'(m_sel));
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 8'hFF; out_ready8 = 1'b0;
    in_valid5 = 5'b0;  out_ready5 = 1'b0;
    for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = word8(k);
    for (int k = 0; k < 5; k++) in_data5[k*32 +: 32] = 32'h5500_0000 + 32'(k);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready",  32'(in_ready8),  32'h0);
    chk("rst_out_valid", 32'(out_valid8), 32'h0);
    chk("rst_out_data",  out_data8,       32'h0);
    chk("rst_out_sel",   32'(out_sel8),   32'h0);

    // Full-rate round robin across all eight channels.
    @(posedge clk); #1; rst = 1'b0; out_ready8 = 1'b1;
    @(negedge clk); #1;
    chk("rr_first_ready", 32'(in_ready8), 32'h01);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("rr_sel",   32'(out_sel8),   32'(i % 8));
      chk("rr_data",  out_data8,       word8(i % 8));
      chk("rr_valid", 32'(out_valid8), 32'h1);
    end

    // Output held under backpressure.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    in_valid8 = 8'h08; out_ready8 = 1'b0; in_data8[3*32 +: 32] = 32'hDEADBEEF;
    @(posedge clk); #1; in_valid8 = 8'hFF;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      chk("hold_data",  out_data8,      32'hDEADBEEF);
      chk("hold_sel",   32'(out_sel8),  32'd3);
      chk("hold_ready", 32'(in_ready8), 32'h0);
      @(posedge clk);
    end
    #1; out_ready8 = 1'b1;
    @(negedge clk); #1;
    chk("release_ready", 32'(in_ready8), 32'h10);
    @(posedge clk); @(negedge clk); #1;
    chk("release_sel", 32'(out_sel8), 32'd4);

    // Reset while a word is pending.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; in_valid8 = 8'hA4;
    @(negedge clk); #1;
    chk("midrst_valid", 32'(out_valid8), 32'h0);
    chk("midrst_data",  out_data8,       32'h0);
    chk("midrst_ready", 32'(in_ready8),  32'h04);
    @(posedge clk); @(negedge clk); #1;
    chk("midrst_sel",  32'(out_sel8), 32'd2);
    chk("midrst_word", out_data8,     word8(2));

    // Single requester, pointer at zero.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; in_valid8 = 8'h40;
    @(negedge clk); #1;
    chk("single_ready", 32'(in_ready8), 32'h40);
    @(posedge clk); @(negedge clk); #1;
    chk("single_sel",   32'(out_sel8),   32'd6);
    chk("single_valid", 32'(out_valid8), 32'h1);

    // N=5: channels 0 and 4 alternate across the 4 -> 0 wrap.
    @(posedge clk); #1; in_valid5 = 5'b10001; out_ready5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk); #1;
      chk("n5_sel",  32'(out_sel5), (i % 2 == 1) ? 32'd4 : 32'd0);
      chk("n5_data", out_data5,     (i % 2 == 1) ? 32'h5500_0004 : 32'h5500_0000);
    end
    in_valid5 = 5'b0;

    // Mixed request/backpressure patterns, checked by the model each cycle.
    begin
      logic [7:0] vpat [7];
      logic       rpat [5];
      vpat = '{8'h00, 8'h81, 8'h3C, 8'hFF, 8'h10, 8'hAA, 8'h55};
      rpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 48; i++) begin
        @(posedge clk); #1;
        in_valid8  = vpat[i % 7];
        out_ready8 = rpat[i % 5];
        for (int k = 0; k < 8; k++) in_data8[k*32 +: 32] = word8(k) ^ 32'(i);
      end
    end

    @(posedge clk); @(negedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arb_mux_rr.md
ARB_MUX_RR -- requirements
Module: arb_mux_rr

Interface
REQ-001 Parameter N, default 8, number of input channels (2..16, any integer).
REQ-002 Parameter W, default 32, data width per channel.
REQ-003 Derived localparam SELW = max(1, clog2(N)), channel index width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N*W  channel k occupies bits [k*W +: W].
REQ-007 in_valid  input  N  per-channel request valid.
REQ-008 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-009 out_data  output  W  registered selected data.
REQ-010 out_sel  output  SELW  registered index of channel that supplied out_data.
REQ-011 out_valid  output  1  out_data/out_sel hold a pending word.
REQ-012 out_ready  input  1  downstream accept.
REQ-013 lock  input  1  hold current grant (present only with ARB_MUX_LOCK_EN, see Configuration).

Function
REQ-014 Transfer on a channel k occurs in a cycle where in_valid[k] and in_ready[k] are both 1; output transfer where out_valid and out_ready are both 1.
REQ-015 load_en = !out_valid | out_ready; in_ready is all-zero when load_en = 0.
REQ-016 Round-robin pointer ptr (SELW bits) names the highest-priority channel; grant = first k with in_valid[k] scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
REQ-017 in_ready = one-hot(grant) & {N{load_en}}; all-zero when no in_valid bit set.
REQ-018 On a channel transfer from g: out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod N; wrap at N-1 -> 0 for non-power-of-2 N.
REQ-019 Output clears (out_valid <= 0) when output transfer occurs and no channel transfer occurs same cycle; simultaneous output and channel transfer reloads, giving full throughput of one word per cycle.
REQ-020 Latency: channel transfer in cycle t -> word visible on out_data/out_valid in cycle t+1.
REQ-021 out_data and out_sel hold stable while out_valid = 1 and out_ready = 0; ptr unchanged in cycles without channel transfer.
REQ-022 in_ready may depend combinationally on in_valid and out_ready; no other combinational input-to-output path; out_* are register outputs only.
REQ-023 Only one in_valid set: that channel granted regardless of ptr; fairness: a continuously valid channel is granted within N channel transfers.

Reset
REQ-024 While rst = 1 at a clock edge: out_valid <= 0, out_data <= 0, out_sel <= 0, ptr <= 0, lock state cleared; in_ready forced all-zero during rst.
REQ-025 Reset mid-operation discards any pending output word; first grant after reset follows ptr = 0.

Configuration
REQ-026 Macro ARB_MUX_LOCK_EN: when defined, port lock and a lock-state register (locked flag + locked channel) exist.
REQ-027 With macro: a channel transfer from g with lock = 1 sets locked <= 1, locked channel <= g; ptr not advanced on locked transfers.
REQ-028 With macro, while locked: grant is only the locked channel (others get in_ready = 0 even if locked channel idle); first channel transfer with lock = 0 clears locked and advances ptr per REQ-018.
REQ-029 Without macro: no lock port, no lock state, pure round-robin per REQ-016..023.

Verification
REQ-030 N=8,W=32; reset, then in_valid=8'hFF, out_ready=1 constant -> out_sel sequence 0,1,2,...,7,0 one per cycle from cycle after first accept, out_data equals matching channel word.
REQ-031 N=5; in_valid=5'b10001, out_ready=1 -> grants alternate 0,4,0,4; ptr wraps 4 -> 0 correctly.
REQ-032 Output held: load word 32'hDEADBEEF from ch 3, out_ready=0 for 4 cycles with all in_valid=1 -> out_data/out_sel stable, in_ready=0; release -> next grant ch 4.
REQ-033 Reset mid-stream: rst=1 one cycle while out_valid=1 -> out_valid=0, out_data=0 next cycle; next grant from lowest valid channel scanning from 0.
REQ-034 ARB_MUX_LOCK_EN: ch 2 transfers with lock=1, then ch 2 idle 2 cycles while ch 5 valid -> in_ready[5]=0; ch 2 transfers with lock=0 -> next grant ch 5 (ptr=3).
REQ-035 Single requester: only in_valid[6]=1, ptr=0, out_ready=1 -> in_ready=8'h40 same cycle, out_sel=6 next cycle.
